// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch PC redirect controller.
// Holds the FSM state encoding, the redirect-source tags and the PC step.
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_SLOT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE     = 2'd0,
    SRC_ID_TAKEN = 2'd1,
    SRC_ID_ANNUL = 2'd2,
    SRC_EX_JR    = 2'd3
  } redir_src_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Fetch addresses are word aligned, so the low two bits are dropped on every load.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Branch-decision and fetch-control bundle between the condition logic and the PC controller.
// master drives branch resolutions and stall; slave owns the fetch PC and flush controls.
interface pc_redirect_ctrl_if;

  logic        stall;
  logic        id_branch_valid;
  logic        id_branch_taken;
  logic        id_branch_likely;
  logic [31:0] id_target;
  logic        ex_jr_valid;
  logic [31:0] ex_jr_target;

  logic [31:0] pc;
  logic        fetch_valid;
  logic        if_flush;
  logic        id_flush;
  logic        ds_violation;
  logic [1:0]  state_dbg;

  modport master (
    output stall, id_branch_valid, id_branch_taken, id_branch_likely, id_target,
    output ex_jr_valid, ex_jr_target,
    input  pc, fetch_valid, if_flush, id_flush, ds_violation, state_dbg
  );

  modport slave (
    input  stall, id_branch_valid, id_branch_taken, id_branch_likely, id_target,
    input  ex_jr_valid, ex_jr_target,
    output pc, fetch_valid, if_flush, id_flush, ds_violation, state_dbg
  );

endinterface

// File: rtl/pc_redirect_ctrl_arbiter.sv
// Combinational priority select for the next fetch PC and the IF/ID flush controls.
// EX JR/JALR beats stall, stall beats ID decisions; nothing is accepted while booting.
module pc_redirect_ctrl_arbiter
  import pc_redirect_ctrl_pkg::*;
#(
  parameter bit DELAY_SLOT = 1'b1
) (
  input  state_t      state,
  input  logic        stall,
  input  logic        id_branch_valid,
  input  logic        id_branch_taken,
  input  logic        id_branch_likely,
  input  logic [31:0] id_target,
  input  logic        ex_jr_valid,
  input  logic [31:0] ex_jr_target,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        if_flush,
  output logic        id_flush,
  output logic        violation_set,
  output redir_src_t  src
);

  logic        id_taken;
  logic [31:0] pc_seq;

  assign id_taken = id_branch_valid & id_branch_taken;
  assign pc_seq   = pc + PC_STEP;

  always_comb begin
    next_pc       = pc;
    if_flush      = 1'b0;
    id_flush      = 1'b0;
    violation_set = 1'b0;
    src           = SRC_NONE;

    if (state != ST_BOOT) begin
      if (ex_jr_valid) begin
        // A taken ID branch here is sitting in the JR delay slot.
        next_pc       = align_pc(ex_jr_target);
        if_flush      = 1'b1;
        id_flush      = !DELAY_SLOT;
        violation_set = id_taken;
        src           = SRC_EX_JR;
      end else if (stall) begin
        next_pc = pc;
      end else if (state == ST_SLOT) begin
        next_pc       = pc_seq;
        violation_set = id_taken;
      end else if (id_taken) begin
        next_pc  = align_pc(id_target);
        if_flush = !DELAY_SLOT;
        src      = SRC_ID_TAKEN;
      end else if (id_branch_valid && id_branch_likely) begin
        next_pc  = pc_seq;
        if_flush = 1'b1;
        src      = SRC_ID_ANNUL;
      end else begin
        next_pc = pc_seq;
      end
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: applies branch/jump redirects with MIPS delay-slot handling.
// state | meaning
// BOOT  | out of reset, RESET_PC not yet fetched, inputs ignored
// RUN   | normal sequential fetch, redirects accepted
// SLOT  | ID holds a taken branch's delay slot; branches there are violations
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  pc_redirect_ctrl_if.slave  bus
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic        if_flush;
  logic        id_flush;
  logic        violation_set;
  logic        ds_violation_q;
  redir_src_t  src;

  pc_redirect_ctrl_arbiter #(
    .DELAY_SLOT (DELAY_SLOT)
  ) u_arbiter (
    .state            (state),
    .stall            (bus.stall),
    .id_branch_valid  (bus.id_branch_valid),
    .id_branch_taken  (bus.id_branch_taken),
    .id_branch_likely (bus.id_branch_likely),
    .id_target        (bus.id_target),
    .ex_jr_valid      (bus.ex_jr_valid),
    .ex_jr_target     (bus.ex_jr_target),
    .pc               (pc_q),
    .next_pc          (next_pc),
    .if_flush         (if_flush),
    .id_flush         (id_flush),
    .violation_set    (violation_set),
    .src              (src)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_BOOT;
      pc_q           <= align_pc(RESET_PC);
      ds_violation_q <= 1'b0;
    end else begin
      state <= state_nxt;
      pc_q  <= next_pc;
      if (violation_set) begin
        ds_violation_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN, ST_SLOT: begin
        if (src == SRC_EX_JR) begin
          state_nxt = ST_RUN;
        end else if (bus.stall) begin
          state_nxt = state;
        end else if (src == SRC_ID_TAKEN && DELAY_SLOT) begin
          state_nxt = ST_SLOT;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  assign bus.pc           = pc_q;
  assign bus.fetch_valid  = (state != ST_BOOT);
  assign bus.if_flush     = if_flush;
  assign bus.id_flush     = id_flush;
  assign bus.ds_violation = ds_violation_q;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench: two controllers (delay slot on / off) share stimulus and are
// compared every cycle against a rule-level model of the fetch PC behaviour.
module tb_pc_redirect_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic clk;
  logic reset_n;

  logic        stall, bv, bt, bl, jr;
  logic [31:0] tgt, jrt;

  int checks;
  int failures;

  // model: mode 0 = booting, 1 = normal, 2 = delay slot in ID
  logic [31:0] m_pc   [2];
  int          m_mode [2];
  bit          m_viol [2];
  logic [31:0] e_pc   [2];
  int          e_mode [2];
  bit          e_viol [2];
  bit          e_iff  [2];
  bit          e_idf  [2];

  pc_redirect_ctrl_if if0 ();
  pc_redirect_ctrl_if if1 ();

  assign if0.stall = stall;  assign if1.stall = stall;
  assign if0.id_branch_valid = bv;  assign if1.id_branch_valid = bv;
  assign if0.id_branch_taken = bt;  assign if1.id_branch_taken = bt;
  assign if0.id_branch_likely = bl; assign if1.id_branch_likely = bl;
  assign if0.id_target = tgt;       assign if1.id_target = tgt;
  assign if0.ex_jr_valid = jr;      assign if1.ex_jr_valid = jr;
  assign if0.ex_jr_target = jrt;    assign if1.ex_jr_target = jrt;

  pc_redirect_ctrl #(.RESET_PC(RPC), .DELAY_SLOT(1'b1)) dut_ds (
    .clk (clk), .reset_n (reset_n), .bus (if0)
  );
  pc_redirect_ctrl #(.RESET_PC(RPC), .DELAY_SLOT(1'b0)) dut_nods (
    .clk (clk), .reset_n (reset_n), .bus (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%h expected=%h at t=%0t", tag, d, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] o_pc(input int d);   return d == 0 ? if0.pc : if1.pc; endfunction
  function automatic logic [31:0] o_st(input int d);   return {30'd0, d == 0 ? if0.state_dbg : if1.state_dbg}; endfunction
  function automatic logic [31:0] o_fv(input int d);   return {31'd0, d == 0 ? if0.fetch_valid : if1.fetch_valid}; endfunction
  function automatic logic [31:0] o_dv(input int d);   return {31'd0, d == 0 ? if0.ds_violation : if1.ds_violation}; endfunction
  function automatic logic [31:0] o_iff(input int d);  return {31'd0, d == 0 ? if0.if_flush : if1.if_flush}; endfunction
  function automatic logic [31:0] o_idf(input int d);  return {31'd0, d == 0 ? if0.id_flush : if1.id_flush}; endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = RPC; m_mode[d] = 0; m_viol[d] = 1'b0;
    end
  endtask

  // dut0 executes the delay slot, dut1 treats it as wrong path
  task automatic model_eval(input int d);
    bit ds;
    bit taken;
    ds = (d == 0);
    taken = bv && bt;
    e_pc[d] = m_pc[d]; e_mode[d] = m_mode[d]; e_viol[d] = m_viol[d];
    e_iff[d] = 1'b0; e_idf[d] = 1'b0;
    if (m_mode[d] == 0) begin
      e_mode[d] = 1;
    end else if (jr) begin
      e_pc[d] = jrt & 32'hFFFF_FFFC;
      e_iff[d] = 1'b1; e_idf[d] = !ds;
      if (taken) e_viol[d] = 1'b1;
      e_mode[d] = 1;
    end else if (stall) begin
      e_mode[d] = m_mode[d];
    end else if (m_mode[d] == 2) begin
      e_pc[d] = m_pc[d] + 32'd4;
      if (taken) e_viol[d] = 1'b1;
      e_mode[d] = 1;
    end else if (taken) begin
      e_pc[d] = tgt & 32'hFFFF_FFFC;
      e_iff[d] = !ds;
      e_mode[d] = ds ? 2 : 1;
    end else begin
      e_pc[d] = m_pc[d] + 32'd4;
      e_iff[d] = bv && bl;
    end
  endtask

  task automatic check_regs(input string sfx);
    for (int d = 0; d < 2; d++) begin
      chk({"pc", sfx}, d, o_pc(d), m_pc[d]);
      chk({"state", sfx}, d, o_st(d), m_mode[d]);
      chk({"fetch_valid", sfx}, d, o_fv(d), {31'd0, m_mode[d] != 0});
      chk({"ds_violation", sfx}, d, o_dv(d), {31'd0, m_viol[d]});
    end
  endtask

  task automatic cycle();
    for (int d = 0; d < 2; d++) model_eval(d);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("if_flush", d, o_iff(d), {31'd0, e_iff[d]});
      chk("id_flush", d, o_idf(d), {31'd0, e_idf[d]});
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = e_pc[d]; m_mode[d] = e_mode[d]; m_viol[d] = e_viol[d];
    end
    check_regs("");
  endtask

  task automatic idle();
    stall = 0; bv = 0; bt = 0; bl = 0; jr = 0; tgt = 0; jrt = 0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0;
    idle();
    model_reset();
    #12;
    check_regs("_rst");
    for (int d = 0; d < 2; d++) begin
      chk("if_flush_rst", d, o_iff(d), 32'd0);
      chk("id_flush_rst", d, o_idf(d), 32'd0);
    end
    reset_n = 1'b1;
    #1;
    check_regs("_boot");

    // boot edge, then sequential fetch 0x104, 0x108
    cycle(); cycle(); cycle();
    chk("seq_pc", 0, o_pc(0), 32'h108);

    // jump to 0x200, then taken branch to 0x400
    jr = 1; jrt = 32'h200; cycle(); idle();
    bv = 1; bt = 1; tgt = 32'h400; cycle(); idle();
    chk("slot_state", 0, o_st(0), 32'd2);
    cycle();

    // not-taken likely at 0x300, then non-likely not-taken
    jr = 1; jrt = 32'h300; cycle(); idle();
    bv = 1; bl = 1; cycle(); idle();
    bv = 1; cycle(); idle();

    // stall with taken branch pending, then release
    stall = 1; bv = 1; bt = 1; tgt = 32'h500;
    cycle(); cycle(); cycle();
    stall = 0; cycle(); idle();
    cycle();

    // JR beats stall; coincident taken ID branch is a violation
    stall = 1; jr = 1; jrt = 32'h800; bv = 1; bt = 1; tgt = 32'h900;
    cycle(); idle();
    cycle();

    // wrap at top of address space, with unaligned target bits
    jr = 1; jrt = 32'hFFFF_FFFF; cycle(); idle();
    cycle();
    chk("wrap_pc", 1, o_pc(1), 32'h0);

    // async reset while dut0 sits in SLOT
    bv = 1; bt = 1; tgt = 32'h600; cycle(); idle();
    jr = 1; bv = 1; bt = 1; jrt = 32'h700;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_regs("_async_rst");
    #2;
    reset_n = 1'b1;
    cycle(); idle();
    cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      jr    = ($urandom_range(0, 9) == 0);
      bv    = ($urandom_range(0, 9) < 4);
      bt    = $urandom_range(0, 1);
      bl    = $urandom_range(0, 1);
      tgt   = $urandom;
      jrt   = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
